// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// rtl/hazard_scoreboard_ctrl_pkg.sv - shared constants and FSM encoding for the ID interlock controller
package hazard_scoreboard_ctrl_pkg;

  localparam int NREGS     = 32;
  localparam int ADDR_W    = 5;
  localparam int MAX_PEND  = 3;
  localparam int CNT_W     = $clog2(MAX_PEND + 1);
  localparam int FLUSH_CYC = 2;
  localparam int FCNT_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

endpackage

// File: rtl/hazard_scoreboard_ctrl_if.sv
// rtl/hazard_scoreboard_ctrl_if.sv - ID/EX/WB signal bundle seen by the interlock controller
interface hazard_scoreboard_ctrl_if;
  import hazard_scoreboard_ctrl_pkg::*;

  logic              id_valid;
  logic              id_use_r1;
  logic              id_use_r2;
  logic [ADDR_W-1:0] id_addr_r1;
  logic [ADDR_W-1:0] id_addr_r2;
  logic              id_reg_wr;
  logic [ADDR_W-1:0] id_addr_rd;
  logic              redirect;
  logic              wb_retire;
  logic [ADDR_W-1:0] wb_addr;
  logic              stall;
  logic              flush_id;
  logic              flush_fe;
  logic              issue;
  logic [NREGS-1:0]  busy_vec;

  modport master (
    output id_valid, id_use_r1, id_use_r2, id_addr_r1, id_addr_r2,
           id_reg_wr, id_addr_rd, redirect, wb_retire, wb_addr,
    input  stall, flush_id, flush_fe, issue, busy_vec
  );

  modport slave (
    input  id_valid, id_use_r1, id_use_r2, id_addr_r1, id_addr_r2,
           id_reg_wr, id_addr_rd, redirect, wb_retire, wb_addr,
    output stall, flush_id, flush_fe, issue, busy_vec
  );

endinterface

// File: rtl/hazard_scoreboard_ctrl_pend_counter.sv
// rtl/hazard_scoreboard_ctrl_pend_counter.sv - saturating up/down count of in-flight writes to one register
module hazard_scoreboard_ctrl_pend_counter #(
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_nz
);

  logic [CNT_W-1:0] r_cnt;

  // Simultaneous inc and dec cancel; both ends hold rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && (r_cnt != CNT_W'(MAX_PEND))) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_nz  = (r_cnt != '0);

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_dec && !i_inc && (r_cnt == '0)));

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// rtl/hazard_scoreboard_ctrl.sv - ID-stage RAW/WAW interlock scoreboard and redirect flush sequencer
module hazard_scoreboard_ctrl
  import hazard_scoreboard_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  hazard_scoreboard_ctrl_if.slave bus
);

  flush_state_e      r_state, w_state_nxt;
  logic [FCNT_W-1:0] r_fcnt, w_fcnt_nxt;
  logic              w_flush, w_raw, w_sat, w_stall, w_issue;
  logic [CNT_W-1:0]  w_cnt [NREGS];
  logic [NREGS-1:0]  w_nz;

  assign w_cnt[0] = '0;
  assign w_nz[0]  = 1'b0;

  for (genvar g = 1; g < NREGS; g++) begin : g_pend
    hazard_scoreboard_ctrl_pend_counter #(
      .MAX_PEND (MAX_PEND),
      .CNT_W    (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_issue && bus.id_reg_wr && (bus.id_addr_rd == ADDR_W'(g))),
      .i_dec (bus.wb_retire && (bus.wb_addr == ADDR_W'(g))),
      .o_cnt (w_cnt[g]),
      .o_nz  (w_nz[g])
    );
  end

  assign w_raw = bus.id_valid &
                 ((bus.id_use_r1 & (bus.id_addr_r1 != '0) & w_nz[bus.id_addr_r1]) |
                  (bus.id_use_r2 & (bus.id_addr_r2 != '0) & w_nz[bus.id_addr_r2]));
  assign w_sat = bus.id_valid & bus.id_reg_wr & (bus.id_addr_rd != '0) &
                 (w_cnt[bus.id_addr_rd] == CNT_W'(MAX_PEND));

  // A flushed ID slot is dead, so it neither stalls nor gets counted.
  assign w_flush = (r_state == ST_FLUSH);
  assign w_stall = (w_raw | w_sat) & ~w_flush;
  assign w_issue = bus.id_valid & ~w_stall & ~w_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.redirect) begin
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = FCNT_W'(FLUSH_CYC - 1);
        end
      end
      ST_FLUSH: begin
        if (bus.redirect) begin
          w_fcnt_nxt = FCNT_W'(FLUSH_CYC - 1);
        end else if (r_fcnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_fcnt_nxt = r_fcnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.stall    = w_stall;
  assign bus.flush_id = w_flush;
  assign bus.flush_fe = w_flush;
  assign bus.issue    = w_issue;
  assign bus.busy_vec = w_nz;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// tb/tb_hazard_scoreboard_ctrl.sv - directed vectors with queued expectations checked by a monitor
module tb_hazard_scoreboard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hazard_scoreboard_ctrl_if bus ();

  hazard_scoreboard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [35:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [31:0] B3 = 32'h0000_0008;
  localparam logic [31:0] B5 = 32'h0000_0020;
  localparam logic [31:0] B7 = 32'h0000_0080;
  localparam logic [31:0] B9 = 32'h0000_0200;

  task automatic vec(input string nm, input logic rst, input logic v,
                     input logic u1, input logic [4:0] a1,
                     input logic u2, input logic [4:0] a2,
                     input logic wr, input logic [4:0] rd,
                     input logic redir, input logic ret, input logic [4:0] wa,
                     input logic e_st, input logic e_fi, input logic e_fe,
                     input logic e_is, input logic [31:0] e_busy);
    exp_t e;
    @(negedge clk);
    rst_n          = rst;
    bus.id_valid   = v;
    bus.id_use_r1  = u1;
    bus.id_addr_r1 = a1;
    bus.id_use_r2  = u2;
    bus.id_addr_r2 = a2;
    bus.id_reg_wr  = wr;
    bus.id_addr_rd = rd;
    bus.redirect   = redir;
    bus.wb_retire  = ret;
    bus.wb_addr    = wa;
    e.nm  = nm;
    e.exp = {e_st, e_fi, e_fe, e_is, e_busy};
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [35:0] act;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {bus.stall, bus.flush_id, bus.flush_fe, bus.issue, bus.busy_vec};
        n_vec++;
        if (act !== e.exp) begin
          n_err++;
          $display("FAIL %s: got {stall,fid,ffe,issue,busy}=%h expected %h", e.nm, act, e.exp);
        end
      end
    end
  end

  initial begin : driver
    int wait_cyc;
    bus.id_valid = 0; bus.id_use_r1 = 0; bus.id_use_r2 = 0;
    bus.id_addr_r1 = 0; bus.id_addr_r2 = 0; bus.id_reg_wr = 0;
    bus.id_addr_rd = 0; bus.redirect = 0; bus.wb_retire = 0; bus.wb_addr = 0;

    //   name            rst v u1 a1 u2 a2 wr rd red ret wa   st fi fe is busy
    vec("reset0",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    vec("reset1",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    vec("x5_write",       1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0,   0, 0, 0, 1, 0);
    vec("x5_raw",         1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, B5);
    vec("x5_raw_retire",  1, 1, 1, 5, 0, 0, 0, 0, 0, 1, 5,   1, 0, 0, 0, B5);
    vec("x5_raw_cleared", 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);
    vec("x0_a",           1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0);
    vec("x0_b",           1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0);
    vec("x7_w1",          1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0,   0, 0, 0, 1, 0);
    vec("x7_w2",          1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0,   0, 0, 0, 1, B7);
    vec("x7_w3",          1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0,   0, 0, 0, 1, B7);
    vec("x7_sat",         1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0,   1, 0, 0, 0, B7);
    vec("x7_sat_retire",  1, 1, 0, 0, 0, 0, 1, 7, 0, 1, 7,   1, 0, 0, 0, B7);
    vec("x7_w4_issue",    1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0,   0, 0, 0, 1, B7);
    vec("x7_full_again",  1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0,   1, 0, 0, 0, B7);
    vec("x7_drain1",      1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 0, 0, 0, B7);
    vec("x7_drain2",      1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 0, 0, 0, B7);
    vec("x7_drain3",      1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 0, 0, 0, B7);
    vec("x7_empty",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    vec("x9_write",       1, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0,   0, 0, 0, 1, 0);
    vec("x9_inc_dec",     1, 1, 0, 0, 0, 0, 1, 9, 0, 1, 9,   0, 0, 0, 1, B9);
    vec("x9_hold",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, B9);
    vec("x9_drain",       1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9,   0, 0, 0, 0, B9);
    vec("x9_empty",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    vec("redir_n",        1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);
    vec("redir_n1",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0);
    vec("redir_n2",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0);
    vec("redir_n3",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    vec("r2_setup",       1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0,   0, 0, 0, 1, 0);
    vec("r2_n",           1, 1, 1, 5, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 0, B5);
    vec("r2_n1",          1, 1, 1, 5, 0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 0, B5);
    vec("r2_n2",          1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, B5);
    vec("r2_n3",          1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, B5);
    vec("r2_n4",          1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, B5);
    vec("r2_drain",       1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5,   0, 0, 0, 0, B5);
    vec("r2_empty",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    vec("x3_w1",          1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0,   0, 0, 0, 1, 0);
    vec("x3_w2_redir",    1, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0,   0, 0, 0, 1, B3);
    vec("x3_in_flush",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, B3);
    vec("rst_mid_flush",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    vec("x3_after_rst",   1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);

    @(negedge clk);
    bus.id_valid = 0;
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
